// File: rtl/uart_fifo_tx.sv
// Buffered 8N1 UART transmitter: a valid/ready byte stream feeds a circular FIFO,
// and a four-state FSM shifts frames out back-to-back on a registered tx_pin.
module uart_fifo_tx #(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_AW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tx_pin,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy
);

  localparam int DIV   = (CLK_FRE * 32'sd1_000_000) / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [FIFO_AW:0]  LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   level_r, level_s;
  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [2:0]         bit_r, bit_s;
  logic [7:0]         shift_r, shift_s;
  logic               tx_r, tx_s;
  logic               busy_r, busy_s;
  logic               push_s, pop_s;

  // Ready depends on the registered level only, so a same-cycle pop never opens it early.
  assign in_ready   = (level_r != LEVEL_FULL);
  assign push_s     = in_valid && in_ready;
  assign tx_pin     = tx_r;
  assign fifo_level = level_r;
  assign busy       = busy_r;

  // Next-state, pop decision and the registered-output values derived from the next state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        bit_s = 3'd0;
        if (level_r != '0) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = '0;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          bit_s = 3'd0;
          // Chain straight into the next start bit when another byte is waiting.
          if (level_r != '0) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        bit_s   = 3'd0;
      end
    endcase

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[bit_s];
      default: tx_s = 1'b1;
    endcase

    case ({push_s, pop_s})
      2'b10:   level_s = level_r + 1'b1;
      2'b01:   level_s = level_r - 1'b1;
      default: level_s = level_r;
    endcase

    busy_s = (state_s != IDLE) || (level_s != '0);
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      level_r <= level_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a default-rate instance and a DIV=9 instance, both checked every
// cycle against a frame-schedule model, plus hand-computed literal checks per scenario.
module tb_uart_fifo_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data    [2];
  logic       in_valid   [2];
  logic       in_ready   [2];
  logic       tx_pin     [2];
  logic [4:0] fifo_level [2];
  logic       busy       [2];

  always #5 clk = ~clk;

  uart_fifo_tx u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx_pin(tx_pin[0]), .fifo_level(fifo_level[0]), .busy(busy[0])
  );

  uart_fifo_tx #(.CLK_FRE(27), .BAUD_RATE(3_000_000), .FIFO_AW(4)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx_pin(tx_pin[1]), .fifo_level(fifo_level[1]), .busy(busy[1])
  );

  int         div_c [2] = '{234, 9};
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         acc_t [2][$];
  int         st_t  [2][$];
  logic [7:0] fr_d  [2][$];
  int         last_start [2] = '{-1000000, -1000000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors < 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Bytes queued at cycle c: accepted strictly before c, minus those whose frame has started by c.
  function automatic int m_level(input int i, input int c);
    int n;
    n = 0;
    for (int k = 0; k < acc_t[i].size(); k++) if (acc_t[i][k] < c) n++;
    for (int k = 0; k < st_t[i].size(); k++) if (st_t[i][k] <= c) n--;
    return n;
  endfunction

  // Line level at cycle c from the frame schedule: start 0, data LSB first, stop 1, idle 1.
  function automatic void m_line(input int i, input int c, output logic active, output logic lvl);
    logic [7:0] b;
    int idx;
    active = 1'b0;
    lvl    = 1'b1;
    for (int k = 0; k < st_t[i].size(); k++) begin
      if (c >= st_t[i][k] && c < st_t[i][k] + 10 * div_c[i]) begin
        active = 1'b1;
        idx    = (c - st_t[i][k]) / div_c[i];
        b      = fr_d[i][k];
        if (idx == 0)      lvl = 1'b0;
        else if (idx == 9) lvl = 1'b1;
        else               lvl = b[idx-1];
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Per-cycle model comparison for both instances.
  initial begin
    int   lvl;
    int   s;
    logic act;
    logic bitv;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          acc_t[i].delete();
          st_t[i].delete();
          fr_d[i].delete();
          last_start[i] = -1000000;
          chk($sformatf("m%0d_rst_tx", i), 32'(tx_pin[i]), 32'd1);
          chk($sformatf("m%0d_rst_level", i), 32'(fifo_level[i]), 32'd0);
          chk($sformatf("m%0d_rst_busy", i), 32'(busy[i]), 32'd0);
          chk($sformatf("m%0d_rst_ready", i), 32'(in_ready[i]), 32'd1);
        end else begin
          lvl = m_level(i, cyc);
          m_line(i, cyc, act, bitv);
          chk($sformatf("m%0d_level", i), 32'(fifo_level[i]), 32'(lvl));
          chk($sformatf("m%0d_level_range", i), 32'(lvl >= 0 && lvl <= 16), 32'd1);
          chk($sformatf("m%0d_ready", i), 32'(in_ready[i]), 32'(lvl < 16));
          chk($sformatf("m%0d_tx", i), 32'(tx_pin[i]), 32'(bitv));
          chk($sformatf("m%0d_busy", i), 32'(busy[i]), 32'(lvl != 0 || act));
          if (in_valid[i] && lvl < 16) begin
            s = (cyc + 2 > last_start[i] + 10 * div_c[i]) ? cyc + 2 : last_start[i] + 10 * div_c[i];
            acc_t[i].push_back(cyc);
            st_t[i].push_back(s);
            fr_d[i].push_back(in_data[i]);
            last_start[i] = s;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    step();
    while (busy[i] && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("m%0d_idle_timeout", i), 32'(n < budget), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n0;
    int         b;
    int         first_full;
    int         lvl_full;
    int         p;
    int         r;
    logic       hs;
    logic [9:0] pat;

    in_data[0]  = 8'h00;
    in_data[1]  = 8'h00;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();

    // Single byte 0x55 on the default-rate instance.
    n0 = cyc;
    in_data[0]  = 8'h55;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    at_cycle(n0 + 1);
    chk("single_level_n1", 32'(fifo_level[0]), 32'd1);
    chk("single_tx_n1", 32'(tx_pin[0]), 32'd1);
    at_cycle(n0 + 2);
    chk("single_tx_start", 32'(tx_pin[0]), 32'd0);
    chk("single_level_n2", 32'(fifo_level[0]), 32'd0);
    at_cycle(n0 + 2 + 233);
    chk("single_start_last", 32'(tx_pin[0]), 32'd0);
    at_cycle(n0 + 2 + 234);
    chk("single_bit0_first", 32'(tx_pin[0]), 32'd1);
    pat = 10'b1010101010;
    for (int k = 1; k < 10; k++) begin
      at_cycle(n0 + 2 + k * 234 + 117);
      chk($sformatf("single_bit%0d", k), 32'(tx_pin[0]), 32'(pat[k]));
    end
    at_cycle(n0 + 2 + 2339);
    chk("single_busy_stop_last", 32'(busy[0]), 32'd1);
    at_cycle(n0 + 2 + 2340);
    chk("single_busy_low", 32'(busy[0]), 32'd0);
    chk("single_tx_idle", 32'(tx_pin[0]), 32'd1);
    step();

    // Burst 0x00..0x13 with in_valid held high.
    b = 0;
    first_full = -1;
    lvl_full = -1;
    for (int it = 0; it < 60000 && b < 20; it++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(b);
      @(negedge clk);
      hs = in_ready[0];
      if (!hs && first_full < 0) begin
        first_full = b;
        lvl_full   = int'(fifo_level[0]);
      end
      step();
      if (hs) b++;
    end
    in_valid[0] = 1'b0;
    chk("burst_accepts_before_full", 32'(first_full), 32'd17);
    chk("burst_level_at_full", 32'(lvl_full), 32'd16);
    chk("burst_all_sent", 32'(b), 32'd20);
    wait_idle(0, 60000);

    // Push on the exact STOP->START pop cycle with three bytes queued.
    n0 = cyc;
    for (int k = 0; k < 4; k++) begin
      in_data[0]  = 8'hC0 + 8'(k);
      in_valid[0] = 1'b1;
      step();
    end
    in_valid[0] = 1'b0;
    at_cycle(n0 + 4);
    chk("simul_level_before", 32'(fifo_level[0]), 32'd3);
    p = n0 + 2 + 2339;
    at_cycle(p - 1);
    step();
    in_data[0]  = 8'hD0;
    in_valid[0] = 1'b1;
    at_cycle(p);
    chk("simul_level_pop_cycle", 32'(fifo_level[0]), 32'd3);
    step();
    in_valid[0] = 1'b0;
    at_cycle(p + 1);
    chk("simul_level_after", 32'(fifo_level[0]), 32'd3);
    chk("simul_next_start", 32'(tx_pin[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset during data bit 4 of 0xA5 with five bytes queued behind it.
    n0 = cyc;
    for (int k = 0; k < 6; k++) begin
      in_data[0]  = (k == 0) ? 8'hA5 : 8'hE0 + 8'(k);
      in_valid[0] = 1'b1;
      step();
    end
    in_valid[0] = 1'b0;
    r = n0 + 2 + 5 * 234 + 100;
    at_cycle(r);
    chk("rstmid_bit4_low", 32'(tx_pin[0]), 32'd0);
    chk("rstmid_level_5", 32'(fifo_level[0]), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_tx", 32'(tx_pin[0]), 32'd1);
    chk("rstmid_level", 32'(fifo_level[0]), 32'd0);
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    chk("rstmid_ready", 32'(in_ready[0]), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    n0 = cyc;
    at_cycle(n0 + 500);
    chk("rstmid_no_resume_tx", 32'(tx_pin[0]), 32'd1);
    chk("rstmid_no_resume_busy", 32'(busy[0]), 32'd0);
    step();

    // DIV = 9 instance: single 0xF0 frame.
    n0 = cyc;
    in_data[1]  = 8'hF0;
    in_valid[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    pat = 10'b1111100000;
    for (int k = 0; k < 10; k++) begin
      at_cycle(n0 + 2 + 9 * k);
      chk($sformatf("div9_bit%0d_first", k), 32'(tx_pin[1]), 32'(pat[k]));
      at_cycle(n0 + 2 + 9 * k + 8);
      chk($sformatf("div9_bit%0d_last", k), 32'(tx_pin[1]), 32'(pat[k]));
    end
    chk("div9_busy_frame_end", 32'(busy[1]), 32'd1);
    at_cycle(n0 + 2 + 90);
    chk("div9_busy_low", 32'(busy[1]), 32'd0);
    chk("div9_tx_idle", 32'(tx_pin[1]), 32'd1);
    step();

    // Pointer wrap: 40 bytes with random valid gaps on the DIV = 9 instance.
    b = 0;
    for (int it = 0; it < 20000 && b < 40; it++) begin
      in_valid[1] = ($urandom_range(0, 2) != 0);
      in_data[1]  = 8'h30 + 8'(b);
      @(negedge clk);
      hs = in_valid[1] && in_ready[1];
      step();
      if (hs) b++;
    end
    in_valid[1] = 1'b0;
    chk("wrap_all_sent", 32'(b), 32'd40);
    wait_idle(1, 20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
